// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int unsigned N_CH = 4;

    typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/stream_slot.sv
// One-entry output holding slot: loads a word, drains on downstream accept.
module stream_slot #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // A load wins over a drain, so a full slot can refill in the cycle it empties.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer with explicit or round-robin targeting.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  ch_idx_t         in_sel,
    input  logic            rr_mode,
    output logic [N_CH-1:0] out_valid,
    input  logic [N_CH-1:0] out_ready,
    output logic [W-1:0]    out_data0,
    output logic [W-1:0]    out_data1,
    output logic [W-1:0]    out_data2,
    output logic [W-1:0]    out_data3,
    output ch_idx_t         rr_ptr
);

    ch_idx_t         tgt;
    ch_idx_t         rr_ptr_d, rr_ptr_q;
    logic            acc;
    logic [N_CH-1:0] load;
    logic [W-1:0]    slot_data [N_CH];

    // Round-robin pointer only moves on acceptance, so a stalled target is never skipped.
    always_comb begin
        tgt       = rr_mode ? rr_ptr_q : in_sel;
        in_ready  = !out_valid[tgt] || out_ready[tgt];
        acc       = in_valid && in_ready;
        load      = '0;
        load[tgt] = acc;
        rr_ptr_d  = rr_ptr_q;
        if (acc && rr_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        stream_slot #(
            .W(W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .load_data(in_data),
            .out_valid(out_valid[i]),
            .out_ready(out_ready[i]),
            .out_data (slot_data[i])
        );
    end

    assign rr_ptr    = rr_ptr_q;
    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: hand table, directed corner sequences, random vs. slot model.
module tb_demux_1_4_stream;
    import demux_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    ch_idx_t      in_sel;
    logic         rr_mode;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    ch_idx_t      rr_ptr;

    demux_1_4_stream #(
        .W(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .rr_mode  (rr_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data0(out_data0),
        .out_data1(out_data1),
        .out_data2(out_data2),
        .out_data3(out_data3),
        .rr_ptr   (rr_ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a word per channel plus a flag saying it is still owed downstream.
    logic         m_valid [4];
    logic [W-1:0] m_data  [4];
    int           m_ptr;
    logic         last_ready;

    // Handshakes of word C on channel 3, used to prove it is delivered exactly once.
    int c_seen = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid[3] && out_ready[3] && out_data3 == 4'hC) c_seen++;
    end

    typedef struct {
        logic        v;
        logic [3:0]  d;
        logic [1:0]  s;
        logic        m;
        logic [3:0]  r;
        logic        e_rdy;
        logic [3:0]  e_val;
        logic [1:0]  e_ptr;
        logic [15:0] e_dat;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [15:0] dut_dat();
        return {out_data3, out_data2, out_data1, out_data0};
    endfunction

    function automatic logic [15:0] mdl_dat();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    function automatic logic [3:0] mdl_val();
        return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
        m_ptr = 0;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input ch_idx_t s, input logic m,
                         input logic [3:0] r);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        rr_mode   = m;
        out_ready = r;
    endtask

    // One clock: check in_ready before the edge, advance the model, check state after it.
    task automatic cycle();
        int           tgt;
        logic         rdy;
        logic [3:0]   hold;
        logic [15:0]  hdat;
        logic [15:0]  mask;
        @(negedge clk);
        tgt  = rr_mode ? m_ptr : int'(in_sel);
        rdy  = !m_valid[tgt] || out_ready[tgt];
        chk("in_ready", 32'(in_ready), 32'(rdy));
        last_ready = in_ready;
        hold = out_valid & ~out_ready;
        hdat = dut_dat();
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
        end
        if (in_valid && rdy) begin
            m_valid[tgt] = 1'b1;
            m_data[tgt]  = in_data;
            if (rr_mode) m_ptr = (m_ptr + 1) % 4;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(mdl_val()));
        chk("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
        chk("out_data", 32'(dut_dat()), 32'(mdl_dat()));
        if (hold != 4'b0) begin
            mask = {{4{hold[3]}}, {4{hold[2]}}, {4{hold[1]}}, {4{hold[0]}}};
            chk("stalled_valid_held", 32'(out_valid & hold), 32'(hold));
            chk("stalled_data_held", 32'(dut_dat() & mask), 32'(hdat & mask));
        end
    endtask

    initial begin
        model_reset();
        last_ready = 1'b1;
        rst_n = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_rr_ptr", 32'(rr_ptr), 32'h0);
        chk("reset_out_data", 32'(dut_dat()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Explicit routing, then round-robin wrap with all outputs ready.
        tbl[0] = '{1'b1, 4'hA, 2'd2, 1'b0, 4'hF, 1'b1, 4'b0100, 2'd0, 16'h0A00};
        tbl[1] = '{1'b1, 4'h5, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0001, 2'd0, 16'h0A05};
        tbl[2] = '{1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 16'h0A05};
        tbl[3] = '{1'b1, 4'h1, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0001, 2'd1, 16'h0A01};
        tbl[4] = '{1'b1, 4'h2, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0010, 2'd2, 16'h0A21};
        tbl[5] = '{1'b1, 4'h3, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0100, 2'd3, 16'h0321};
        tbl[6] = '{1'b1, 4'h4, 2'd3, 1'b1, 4'hF, 1'b1, 4'b1000, 2'd0, 16'h4321};
        tbl[7] = '{1'b1, 4'h5, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0001, 2'd1, 16'h4325};
        tbl[8] = '{1'b0, 4'h0, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0000, 2'd1, 16'h4325};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].m, tbl[i].r);
            cycle();
            chk($sformatf("tbl%0d_in_ready", i), 32'(last_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d_rr_ptr", i), 32'(rr_ptr), 32'(tbl[i].e_ptr));
            chk($sformatf("tbl%0d_out_data", i), 32'(dut_dat()), 32'(tbl[i].e_dat));
        end

        // Asynchronous reset mid-cycle with slots 0 and 2 full.
        drive(1'b1, 4'h6, 2'd0, 1'b0, 4'b0000);
        cycle();
        drive(1'b1, 4'h9, 2'd2, 1'b0, 4'b0000);
        cycle();
        drive(1'b0, 4'h0, 2'd0, 1'b0, 4'b0000);
        chk("pre_reset_full", 32'(out_valid), 32'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_out_valid", 32'(out_valid), 32'h0);
        chk("async_reset_rr_ptr", 32'(rr_ptr), 32'h0);
        chk("async_reset_out_data", 32'(dut_dat()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = ch_idx_t'(s);
            #1;
            chk($sformatf("post_reset_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
        end
        @(posedge clk);
        #1;

        // Round-robin backpressure: channel 1 never drains until released.
        drive(1'b1, 4'h7, 2'd0, 1'b1, 4'b1101);
        cycle();
        drive(1'b1, 4'h8, 2'd0, 1'b1, 4'b1101);
        cycle();
        drive(1'b1, 4'h9, 2'd0, 1'b1, 4'b1101);
        cycle();
        chk("bp_word9_accepted_ptr", 32'(rr_ptr), 32'h3);
        drive(1'b1, 4'hA, 2'd0, 1'b1, 4'b1101);
        cycle();
        drive(1'b1, 4'hB, 2'd0, 1'b1, 4'b1101);
        cycle();
        drive(1'b1, 4'hC, 2'd0, 1'b1, 4'b1101);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("bp_stall_in_ready", 32'(last_ready), 32'h0);
            chk("bp_stall_ptr_frozen", 32'(rr_ptr), 32'h1);
        end
        out_ready = 4'b1111;
        cycle();
        chk("bp_release_in_ready", 32'(last_ready), 32'h1);
        chk("bp_release_ptr", 32'(rr_ptr), 32'h2);
        drive(1'b0, 4'h0, 2'd0, 1'b1, 4'b1111);
        cycle();

        // Simultaneous drain and load on channel 3.
        drive(1'b1, 4'hC, 2'd3, 1'b0, 4'b0111);
        cycle();
        begin
            int c_base;
            c_base = c_seen;
            drive(1'b1, 4'hD, 2'd3, 1'b0, 4'b1111);
            cycle();
            chk("dl_in_ready_full_slot", 32'(last_ready), 32'h1);
            chk("dl_valid3", 32'(out_valid[3]), 32'h1);
            chk("dl_data3", 32'(out_data3), 32'hD);
            drive(1'b0, 4'h0, 2'd3, 1'b0, 4'b1111);
            cycle();
            chk("dl_c_seen_once", 32'(c_seen - c_base), 32'h1);
        end

        // Mode switch keeps the pointer.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 1), 2'd1, 1'b0, 4'b1111);
            cycle();
            chk("ms_ptr_held", 32'(rr_ptr), 32'h2);
        end
        drive(1'b1, 4'hE, 2'd0, 1'b1, 4'b1111);
        cycle();
        chk("ms_rr_resume_valid2", 32'(out_valid[2]), 32'h1);
        chk("ms_rr_resume_data2", 32'(out_data2), 32'hE);
        chk("ms_rr_resume_ptr", 32'(rr_ptr), 32'h3);

        // Random traffic; upstream holds its word while stalled.
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !last_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
                in_sel   = ch_idx_t'($urandom);
                rr_mode  = ($urandom_range(0, 1) == 1);
            end
            out_ready = 4'($urandom) | 4'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
